// File: rtl/crp_mem_pkg.sv
// Shared types and widths for the CRP pin-level memory responder.
// Request/data widths and the responder FSM state encoding.
package crp_mem_pkg;
   localparam int REQ_W  = 15;
   localparam int DATA_W = 8;

   typedef enum logic {
      ST_IDLE,
      ST_WDATA
   } crp_mem_state_t;
endpackage

// File: rtl/crp_mem_array.sv
// Single-port byte RAM: synchronous write, registered read-old-data.
// Ports: clk, we, addr, wdata, rdata.
module crp_mem_array
  import crp_mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/crp_mem_responder.sv
// CRP memory responder: pin-level reads, two-phase writes, optional
// boot ROM (macro CRP_MEM_BOOTROM_EN). Ports: clk, rst_n, req_bus,
// write_req, read_data, write_phase, rom_wr_err.
module crp_mem_responder
   import crp_mem_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int BOOT_WORDS = 64,
   parameter     INIT_FILE  = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REQ_W-1:0]  req_bus,
   input  logic              write_req,
   output logic [DATA_W-1:0] read_data,
   output logic              write_phase,
   output logic              rom_wr_err
);

   localparam int AW = $clog2(DEPTH);

`ifdef CRP_MEM_BOOTROM_EN
   localparam bit ROM_EN = 1'b1;
`else
   localparam bit ROM_EN = 1'b0;
`endif

   crp_mem_state_t    state;
   logic [AW-1:0]     addr_reg;
   logic              rd_vld;
   logic              byp_sel;
   logic [DATA_W-1:0] byp_data;
   logic [DATA_W-1:0] ram_q;
   logic              err_q;
   logic              data_cyc;
   logic              rom_hit;
   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic              unused_req;

   assign unused_req = ^req_bus;

   assign data_cyc = (state == ST_WDATA) && write_req;
   assign rom_hit  = ROM_EN && (int'(addr_reg) < BOOT_WORDS);
   assign ram_we   = data_cyc && !rom_hit;
   // The single port serves the latched address only on a data cycle.
   assign ram_addr = data_cyc ? addr_reg : req_bus[AW-1:0];

   crp_mem_array #(
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (req_bus[DATA_W-1:0]),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         addr_reg <= '0;
         rd_vld   <= 1'b0;
         byp_sel  <= 1'b0;
         byp_data <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_vld   <= 1'b1;
         byp_sel  <= ram_we;
         byp_data <= req_bus[DATA_W-1:0];
         err_q    <= data_cyc && rom_hit;
         unique case (state)
            ST_IDLE: begin
               if (write_req) begin
                  addr_reg <= req_bus[AW-1:0];
                  state    <= ST_WDATA;
               end
            end
            ST_WDATA: begin
               // Data cycle or abort: both return to IDLE.
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // rd_vld forces zero from reset until the first sampling edge,
   // since the RAM output register itself has no reset.
   assign read_data   = !rd_vld ? '0 : (byp_sel ? byp_data : ram_q);
   assign write_phase = (state == ST_WDATA);
   assign rom_wr_err  = err_q;

endmodule

// File: tb/tb_crp_mem_responder.sv
// Self-checking bench for crp_mem_responder: vector table,
// behavioural model with scoreboard queue, reset corner cases.
module tb_crp_mem_responder;

`ifdef CRP_MEM_BOOTROM_EN
   localparam bit ROM = 1'b1;
`else
   localparam bit ROM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [14:0] bus = '0;
   logic        wr = 1'b0;
   logic [7:0]  read_data;
   logic        write_phase;
   logic        rom_wr_err;

   crp_mem_responder #(
      .DEPTH      (256),
      .BOOT_WORDS (64),
      .INIT_FILE  ("")
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_bus     (bus),
      .write_req   (wr),
      .read_data   (read_data),
      .write_phase (write_phase),
      .rom_wr_err  (rom_wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rd;
      bit         wp;
      bit         er;
   } exp_t;

   typedef struct {
      bit          w;
      logic [14:0] b;
      logic [7:0]  rd;
      bit          wp;
   } vec_t;

   exp_t       sbq[$];
   vec_t       vecs[15];
   logic [7:0] mm [256];
   bit         m_wd;
   logic [7:0] m_a;
   int         checks = 0;
   int         fails = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [7:0] initv(input int a);
      logic [7:0] v;
      v = 8'(a) ^ 8'hC3;
      case (a)
         'h10: v = 8'hA5;
         'h30: v = 8'h11;
         'h31: v = 8'h22;
         default: ;
      endcase
      return v;
   endfunction

   task automatic mdl(input bit w, input logic [14:0] b,
                      output exp_t e);
      logic [7:0] a;
      a = b[7:0];
      e.er = 1'b0;
      if (m_wd && w) begin
         if (ROM && m_a < 8'd64) e.er = 1'b1;
         else mm[m_a] = b[7:0];
         e.rd = mm[m_a];
         m_wd = 1'b0;
      end else if (w) begin
         m_a  = a;
         e.rd = mm[a];
         m_wd = 1'b1;
      end else begin
         e.rd = mm[a];
         m_wd = 1'b0;
      end
      e.wp = m_wd;
   endtask

   // Called at a negedge; drives one cycle and checks its result.
   task automatic step(input bit w, input logic [14:0] b,
                       input bit tab, input logic [7:0] trd,
                       input bit twp, input string nm);
      exp_t e;
      exp_t g;
      wr  = w;
      bus = b;
      mdl(w, b, e);
      if (tab) begin
         e.rd = trd;
         e.wp = twp;
      end
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (sbq.size() == 0) begin
         chk({nm, "_sbq_empty"}, 32'd1, 32'd0);
      end else begin
         g = sbq.pop_front();
         chk({nm, "_rd"}, 32'(read_data), 32'(g.rd));
         chk({nm, "_wp"}, 32'(write_phase), 32'(g.wp));
         chk({nm, "_err"}, 32'(rom_wr_err), 32'(g.er));
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_rd"}, 32'(read_data), 32'h0);
      chk({nm, "_wp"}, 32'(write_phase), 32'h0);
      chk({nm, "_err"}, 32'(rom_wr_err), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 15'h0010, 8'hA5, 1'b0};
      vecs[1]  = '{1'b1, 15'h0020, 8'hE3, 1'b1};
      vecs[2]  = '{1'b1, 15'h4A3C, 8'h3C, 1'b0};
      vecs[3]  = '{1'b0, 15'h0020, 8'h3C, 1'b0};
      vecs[4]  = '{1'b1, 15'h7F05, 8'hC6, 1'b1};
      vecs[5]  = '{1'b1, 15'h0077, 8'h77, 1'b0};
      vecs[6]  = '{1'b0, 15'h0005, 8'h77, 1'b0};
      vecs[7]  = '{1'b1, 15'h0030, 8'h11, 1'b1};
      vecs[8]  = '{1'b0, 15'h0031, 8'h22, 1'b0};
      vecs[9]  = '{1'b0, 15'h0030, 8'h11, 1'b0};
      vecs[10] = '{1'b1, 15'h0040, 8'h83, 1'b1};
      vecs[11] = '{1'b1, 15'h0099, 8'h99, 1'b0};
      vecs[12] = '{1'b1, 15'h0041, 8'h82, 1'b1};
      vecs[13] = '{1'b1, 15'h0055, 8'h55, 1'b0};
      vecs[14] = '{1'b0, 15'h0041, 8'h55, 1'b0};

      m_wd = 1'b0;
      m_a  = '0;
      for (int a = 0; a < 256; a++) mm[a] = 'x;
      if (ROM) begin
         for (int a = 0; a < 64; a++) begin
            dut.u_array.mem[a] = 8'(a) + 8'h0F;
            mm[a] = 8'(a) + 8'h0F;
         end
      end

      // Reset values, held across a clock edge.
      #1;
      chk_reset_vals("reset_t0");
      @(posedge clk);
      #1;
      chk_reset_vals("reset_edge");
      @(negedge clk);
      rst_n = 1'b1;

      // Fill writable storage through the pin interface.
      for (int a = 0; a < 256; a++) begin
         if (!(ROM && a < 64)) begin
            step(1'b1, 15'(a), 1'b0, 8'h0, 1'b0, "init_a");
            step(1'b1, {7'h0, initv(a)}, 1'b0, 8'h0, 1'b0, "init_d");
         end
      end

      // Asynchronous reset assertion; contents must persist.
      wr    = 1'b0;
      bus   = 15'h0010;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      m_wd = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;

      if (!ROM) begin
         for (int i = 0; i < 15; i++)
            step(vecs[i].w, vecs[i].b, 1'b1, vecs[i].rd, vecs[i].wp,
                 $sformatf("vec%0d", i));

         // Reset in the data phase drops the pending write.
         step(1'b1, 15'h0050, 1'b1, 8'h93, 1'b1, "midrst_a");
         wr    = 1'b1;
         bus   = 15'h00EE;
         rst_n = 1'b0;
         #1;
         chk_reset_vals("midrst");
         m_wd = 1'b0;
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         step(1'b0, 15'h0050, 1'b1, 8'h93, 1'b0, "midrst_rd");
      end else begin
         step(1'b1, 15'h0003, 1'b0, 8'h0, 1'b0, "rom_a");
         step(1'b1, 15'h00FF, 1'b0, 8'h0, 1'b0, "rom_d");
         chk("rom_drop_rd", 32'(read_data), 32'h12);
         chk("rom_pulse", 32'(rom_wr_err), 32'h1);
         step(1'b0, 15'h0003, 1'b0, 8'h0, 1'b0, "rom_rd");
         chk("rom_keep", 32'(read_data), 32'h12);
         chk("rom_pulse_end", 32'(rom_wr_err), 32'h0);
         step(1'b1, 15'h0040, 1'b0, 8'h0, 1'b0, "ram_a");
         step(1'b1, 15'h00AB, 1'b0, 8'h0, 1'b0, "ram_d");
         chk("ram_no_pulse", 32'(rom_wr_err), 32'h0);
         step(1'b0, 15'h0040, 1'b0, 8'h0, 1'b0, "ram_rd");
         chk("ram_wrote", 32'(read_data), 32'hAB);
         step(1'b1, 15'h0003, 1'b0, 8'h0, 1'b0, "rom_ab_a");
         step(1'b0, 15'h0041, 1'b0, 8'h0, 1'b0, "rom_ab");
      end

      // Random traffic against the model.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 2) == 0, 15'($urandom), 1'b0,
              8'h0, 1'b0, "rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
